// File: rtl/sram_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_init_pkg
//  Description : Shared types and constants for the port-0 initiator of the
//                32x512 OpenRAM macro.
//                - FSM state encoding (IDLE, ISSUE, RD_WAIT, RESP)
//                - default address/data/byte-lane widths
//                - request/response struct typedefs for bus-side logic
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_init_pkg;

    localparam int c_ADDR_WIDTH = 9;
    localparam int c_DATA_WIDTH = 32;
    localparam int c_NUM_WMASKS = c_DATA_WIDTH / 8;
    localparam int c_STAT_WIDTH = 16;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_RD_WAIT = 2'd2;
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = c_ST_IDLE,
        ISSUE   = c_ST_ISSUE,
        RD_WAIT = c_ST_RD_WAIT,
        RESP    = c_ST_RESP
    } state_t;

    // Request/response bundles at the default macro geometry, for the
    // user-project bus logic that feeds this initiator.
    typedef struct packed {
        logic                    we;
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] wdata;
        logic [c_NUM_WMASKS-1:0] wmask;
    } req_t;

    typedef struct packed {
        logic                    we;
        logic [c_DATA_WIDTH-1:0] rdata;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/sram_init_stats.sv
`default_nettype none
// ============================================================================
//  Module      : sram_init_stats
//  Description : Free-running wrap-around counters of accepted read and write
//                requests. Built only when SRAM_INIT_STATS_EN is defined.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_rd_acc       - one-cycle pulse per accepted read
//                i_wr_acc       - one-cycle pulse per accepted write
//                o_rd_cnt       - accepted read count
//                o_wr_cnt       - accepted write count
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_init_stats
    import sram_init_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rd_acc,
    input  logic                    i_wr_acc,
    output logic [c_STAT_WIDTH-1:0] o_rd_cnt,
    output logic [c_STAT_WIDTH-1:0] o_wr_cnt
);

    logic [c_STAT_WIDTH-1:0] r_rd_cnt;
    logic [c_STAT_WIDTH-1:0] r_wr_cnt;

    // Natural binary overflow gives the FFFF -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (i_rd_acc) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (i_wr_acc) r_wr_cnt <= r_wr_cnt + 1'b1;
        end
    end

    assign o_rd_cnt = r_rd_cnt;
    assign o_wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: rtl/sram_port0_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port0_initiator
//  Description : Initiator for the 1RW port 0 of the 32x512 OpenRAM macro.
//                Accepts one word read/write request at a time on a
//                valid/ready channel, drives the macro command registers for
//                exactly one cycle, captures dout0 and returns one in-order
//                response on a valid/ready channel.
//                Latency from acceptance edge A: write response at A+1, read
//                response at A+2.
//  Ports       : wb_clk_i, wb_rst_i               - clock (also macro clk0),
//                                                   sync active-high reset
//                req_valid/req_ready/req_we/req_addr/req_wdata/req_wmask
//                rsp_valid/rsp_ready/rsp_we/rsp_rdata
//                sram_csb0/web0/wmask0/addr0/din0 - registered macro command
//                sram_dout0                       - macro read data
//                stat_rd_cnt/stat_wr_cnt          - only with SRAM_INIT_STATS_EN
//  Config      : SRAM_INIT_STATS_EN adds the accepted-request counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port0_initiator
    import sram_init_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int NUM_WMASKS = c_NUM_WMASKS
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
`ifdef SRAM_INIT_STATS_EN
    output logic [15:0]           stat_rd_cnt,
    output logic [15:0]           stat_wr_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    state_t                r_state,      w_state_nxt;
    logic                  r_req_ready,  w_req_ready_nxt;
    logic                  r_rsp_valid,  w_rsp_valid_nxt;
    logic                  r_rsp_we,     w_rsp_we_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
    logic                  r_csb0,       w_csb0_nxt;
    logic                  r_web0,       w_web0_nxt;
    logic [NUM_WMASKS-1:0] r_wmask0,     w_wmask0_nxt;
    logic [ADDR_WIDTH-1:0] r_addr0,      w_addr0_nxt;
    logic [DATA_WIDTH-1:0] r_din0,       w_din0_nxt;
    logic                  w_accept;

    // req_ready is registered, so it only ever rises in IDLE.
    assign w_accept = (r_state == IDLE) && r_req_ready && req_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_we_nxt    = r_rsp_we;
        w_rsp_rdata_nxt = r_rsp_rdata;
        // Chip select and write enable fall back to idle-high every cycle so
        // csb0 is low for exactly the one cycle after acceptance.
        w_csb0_nxt      = 1'b1;
        w_web0_nxt      = 1'b1;
        w_wmask0_nxt    = r_wmask0;
        w_addr0_nxt     = r_addr0;
        w_din0_nxt      = r_din0;

        case (r_state)
            IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_req_ready_nxt = 1'b0;
                    w_csb0_nxt      = 1'b0;
                    w_web0_nxt      = ~req_we;
                    w_addr0_nxt     = req_addr;
                    w_din0_nxt      = req_wdata;
                    w_wmask0_nxt    = req_we ? req_wmask : '0;
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                // r_web0 still holds the command the macro samples this edge.
                if (!r_web0) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_we_nxt    = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_state_nxt     = RESP;
                end else begin
                    w_state_nxt     = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // dout0 settles after the preceding negedge plus macro delay.
                w_rsp_valid_nxt = 1'b1;
                w_rsp_we_nxt    = 1'b0;
                w_rsp_rdata_nxt = sram_dout0;
                w_state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_csb0      <= 1'b1;
            r_web0      <= 1'b1;
            r_wmask0    <= '0;
            r_addr0     <= '0;
            r_din0      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_we    <= w_rsp_we_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_csb0      <= w_csb0_nxt;
            r_web0      <= w_web0_nxt;
            r_wmask0    <= w_wmask0_nxt;
            r_addr0     <= w_addr0_nxt;
            r_din0      <= w_din0_nxt;
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_we      = r_rsp_we;
    assign rsp_rdata   = r_rsp_rdata;
    assign sram_csb0   = r_csb0;
    assign sram_web0   = r_web0;
    assign sram_wmask0 = r_wmask0;
    assign sram_addr0  = r_addr0;
    assign sram_din0   = r_din0;

`ifdef SRAM_INIT_STATS_EN
    sram_init_stats u_stats (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .i_rd_acc (w_accept && !req_we),
        .i_wr_acc (w_accept &&  req_we),
        .o_rd_cnt (stat_rd_cnt),
        .o_wr_cnt (stat_wr_cnt)
    );
`endif

endmodule
`default_nettype wire
